regfile_write_queue: RTL and testbench
======================================

// Module: regfile_write_queue
// PURPOSE
//   Writer-side front end for the 4x8 register file: buffers register writes from the datapath
//   in an in-order FIFO and drives the file's single write port (write_bit/selector_e/data_in).
//   Read-side forwarding covers queued entries, so operand reads always see the newest value.
//   Sits between execute/writeback and the register file; drain_en stalls commits.
// PARAMETERS
//   DEPTH   4   queue entries; power of two, >= 2
//   DATA_W  8   register data width
//   SEL_W   2   register selector width (2**SEL_W registers)
// PORTS
//   CLK         in   1              clock, all state on rising edge
//   areset      in   1              reset, synchronous, active-high
//   wr_valid    in   1              write request valid
//   wr_ready    out  1              request accepted when wr_valid && wr_ready at edge
//   wr_sel      in   SEL_W          destination register of request
//   wr_data     in   DATA_W         data of request
//   drain_en    in   1              permit committing head entry this cycle
//   write_bit   out  1              register file write enable
//   selector_e  out  SEL_W          register file write selector
//   data_in     out  DATA_W         register file write data
//   rd_sel_a    in   SEL_W          port A read selector (same as file's selector_a)
//   rd_sel_b    in   SEL_W          port B read selector (same as file's selector_b)
//   rf_data_a   in   DATA_W         register file data_out_a
//   rf_data_b   in   DATA_W         register file data_out_b
//   fwd_data_a  out  DATA_W         forwarded port A operand
//   fwd_data_b  out  DATA_W         forwarded port B operand
//   level       out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
//   empty       out  1              level == 0
// BEHAVIOUR
//   - Reset (areset high at edge): level=0, pointers=0, all entries discarded, incl. mid-drain.
//     While areset is high: wr_ready=0, write_bit=0; pushes ignored.
//   - Circular buffer, head/tail pointers wrap modulo DEPTH; entries commit in accept order.
//   - wr_ready = !areset && level<DEPTH (registered state only; never depends on wr_valid).
//   - Push at edge when wr_valid && wr_ready: entry {wr_sel,wr_data} written at tail.
//   - Write port, combinational from head: write_bit = drain_en && !empty && !areset;
//     selector_e/data_in = head entry when !empty, else 0. Pop at edge when write_bit=1.
//   - Latency: request accepted at edge N appears at write port in cycle N+1; commits at edge
//     N+1 if drain_en=1 and it is head. Throughput: one commit per cycle.
//   - Push and pop on same edge: level unchanged. Push when full: impossible (wr_ready=0),
//     even if a pop happens that edge.
//   - Forwarding: fwd_data_a = data of newest queued entry with sel==rd_sel_a, else rf_data_a;
//     same for B. Head entry being committed this cycle still forwards (file updates at edge).
//     Request presented on wr_* this cycle is NOT forwarded.
//   - level/empty registered-state derived; empty=1, level=0 out of reset.
// CONFIGURATION
//   REGFILE_WQ_COALESCE_EN defined: push whose wr_sel equals tail entry's sel, level>0, and
//     not (level==1 && pop this edge) overwrites tail data in place; level unchanged.
//     wr_ready then = !areset && (level<DEPTH || coalesce condition true), combinational in wr_sel.
//   Undefined: every accepted push allocates a new entry; no coalescing.
// TESTING
//   1. Reset; push R1=0x07, drain_en=1 -> next cycle write_bit=1,selector_e=1,data_in=0x07; then write_bit=0, empty=1.
//   2. drain_en=0; push R0=0x11,R1=0x22,R2=0x33,R3=0x44 -> level=4, wr_ready=0; 5th push R0=0x55 dropped;
//      drain_en=1 -> four consecutive commits 0x11,0x22,0x33,0x44 in order, then empty.
//   3. drain_en=0; push R2=0x10, R2=0x20; rd_sel_a=2, rf_data_a=0x00, rd_sel_b=3, rf_data_b=0x5A
//      -> fwd_data_a=0x20, fwd_data_b=0x5A.
//   4. level=2, drain_en=1, push R3=0x99 same cycle -> level stays 2; 0x99 commits after older entries.
//   5. level=3, areset high one cycle -> level=0, empty=1, write_bit=0; no queued write ever commits.
//   6. drain_en=0; push R1=0x01 then R1=0x02 -> with REGFILE_WQ_COALESCE_EN level=1, one commit 0x02;
//      without, level=2, commits 0x01 then 0x02.

Source files
------------

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: in-order write buffer in front of the 4x8 register file.
// Queues datapath writes, drives the file's single write port from the head
// entry, and forwards the newest queued value of a register to both read ports.
// Optional feature macro: REGFILE_WQ_COALESCE_EN merges a push that targets the
// same register as the tail entry into that entry instead of allocating a new one.
//
// Handshake: a request transfers on a rising edge where wr_valid && wr_ready;
// wr_ready never looks at wr_valid, and wr_valid may be raised regardless of wr_ready.
// The write port has no backpressure: write_bit=1 means the head commits at this edge.
module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic                     CLK,
  input  logic                     areset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [SEL_W-1:0]         wr_sel,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     drain_en,
  output logic                     write_bit,
  output logic [SEL_W-1:0]         selector_e,
  output logic [DATA_W-1:0]        data_in,
  input  logic [SEL_W-1:0]         rd_sel_a,
  input  logic [SEL_W-1:0]         rd_sel_b,
  input  logic [DATA_W-1:0]        rf_data_a,
  input  logic [DATA_W-1:0]        rf_data_b,
  output logic [DATA_W-1:0]        fwd_data_a,
  output logic [DATA_W-1:0]        fwd_data_b,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [SEL_W-1:0]  r_sel  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [LVL_W-1:0]  r_level;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_alloc;
  logic              w_merge;
  logic              w_coalesce;
  logic [PTR_W-1:0]  w_tail_last;
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;

  assign w_full      = (r_level == LVL_W'(DEPTH));
  assign w_empty     = (r_level == '0);
  assign w_tail_last = r_tail - 1'b1;

  // Head commits whenever draining is permitted and something is queued.
  assign w_pop = drain_en && !w_empty && !areset;

`ifdef REGFILE_WQ_COALESCE_EN
  // Merge into the tail unless that tail is the lone entry leaving this edge,
  // in which case the write would be lost, so a fresh entry is allocated.
  assign w_coalesce = !w_empty && (r_sel[w_tail_last] == wr_sel) &&
                      !((r_level == LVL_W'(1)) && w_pop);
  assign wr_ready   = !areset && (!w_full || w_coalesce);
`else
  assign w_coalesce = 1'b0;
  assign wr_ready   = !areset && !w_full;
`endif

  assign w_push  = wr_valid && wr_ready;
  assign w_alloc = w_push && !w_coalesce;
  assign w_merge = w_push && w_coalesce;

  // Pointer and occupancy bookkeeping; reset discards every queued entry.
  always_ff @(posedge CLK) begin
    if (areset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
    end else begin
      if (w_alloc) r_tail <= r_tail + 1'b1;
      if (w_pop)   r_head <= r_head + 1'b1;
      case ({w_alloc, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Entry storage; contents are only meaningful inside the occupied window.
  always_ff @(posedge CLK) begin
    if (w_alloc) begin
      r_sel[r_tail]  <= wr_sel;
      r_data[r_tail] <= wr_data;
    end
    if (w_merge) begin
      r_data[w_tail_last] <= wr_data;
    end
  end

  // Scan oldest to newest so the youngest matching entry wins; the entry
  // committing this cycle still counts because the file updates at the edge.
  always_comb begin
    w_fwd_a = rf_data_a;
    w_fwd_b = rf_data_b;
    for (int i = 0; i < DEPTH; i++) begin
      if (LVL_W'(i) < r_level) begin
        if (r_sel[r_head + PTR_W'(i)] == rd_sel_a) w_fwd_a = r_data[r_head + PTR_W'(i)];
        if (r_sel[r_head + PTR_W'(i)] == rd_sel_b) w_fwd_b = r_data[r_head + PTR_W'(i)];
      end
    end
  end

  assign write_bit  = w_pop;
  assign selector_e = w_empty ? '0 : r_sel[r_head];
  assign data_in    = w_empty ? '0 : r_data[r_head];
  assign fwd_data_a = w_fwd_a;
  assign fwd_data_b = w_fwd_b;
  assign level      = r_level;
  assign empty      = w_empty;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are checked while
// inputs are stable, well before the next rising edge.
module tb_regfile_write_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  logic              CLK = 1'b0;
  logic              areset;
  logic              wr_valid;
  logic              wr_ready;
  logic [SEL_W-1:0]  wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic              drain_en;
  logic              write_bit;
  logic [SEL_W-1:0]  selector_e;
  logic [DATA_W-1:0] data_in;
  logic [SEL_W-1:0]  rd_sel_a;
  logic [SEL_W-1:0]  rd_sel_b;
  logic [DATA_W-1:0] rf_data_a;
  logic [DATA_W-1:0] rf_data_b;
  logic [DATA_W-1:0] fwd_data_a;
  logic [DATA_W-1:0] fwd_data_b;
  logic [2:0]        level;
  logic              empty;

  int n_cmp = 0;
  int n_err = 0;

  // expected commits, {sel, data}, oldest first
  logic [SEL_W+DATA_W-1:0] exp_q[$];

  regfile_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .CLK(CLK), .areset(areset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_data(wr_data),
    .drain_en(drain_en),
    .write_bit(write_bit), .selector_e(selector_e), .data_in(data_in),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
    .level(level), .empty(empty)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic push(input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] data);
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_data  = data;
    tick();
    wr_valid = 1'b0;
  endtask

  // scoreboard: drain n entries, each must appear at the port in queue order
  task automatic drain_check(input int n, input string tag);
    logic [SEL_W+DATA_W-1:0] e;
    drain_en = 1'b1;
    #1;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check_eq({tag, "_wbit"}, 32'(write_bit), 32'd1);
      check_eq({tag, "_commit"}, 32'({selector_e, data_in}), 32'(e));
      tick();
    end
    check_eq({tag, "_wbit_done"}, 32'(write_bit), 32'd0);
    check_eq({tag, "_empty_done"}, 32'(empty), 32'd1);
    drain_en = 1'b0;
  endtask

  initial begin
    areset    = 1'b1;
    wr_valid  = 1'b0;
    wr_sel    = '0;
    wr_data   = '0;
    drain_en  = 1'b0;
    rd_sel_a  = '0;
    rd_sel_b  = '0;
    rf_data_a = '0;
    rf_data_b = '0;
    tick();
    tick();

    // reset state
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_ready", 32'(wr_ready), 32'd0);
    drain_en = 1'b1;
    #1;
    check_eq("rst_wbit", 32'(write_bit), 32'd0);
    areset = 1'b0;
    #1;
    check_eq("ready_after_rst", 32'(wr_ready), 32'd1);

    // test 1: single push, commit next cycle
    wr_valid = 1'b1; wr_sel = 2'd1; wr_data = 8'h07;
    #1;
    check_eq("t1_no_early_wbit", 32'(write_bit), 32'd0);
    tick();
    wr_valid = 1'b0;
    check_eq("t1_wbit", 32'(write_bit), 32'd1);
    check_eq("t1_sel", 32'(selector_e), 32'd1);
    check_eq("t1_data", 32'(data_in), 32'h07);
    check_eq("t1_level", 32'(level), 32'd1);
    tick();
    check_eq("t1_wbit_after", 32'(write_bit), 32'd0);
    check_eq("t1_empty", 32'(empty), 32'd1);
    check_eq("t1_port_sel_zero", 32'(selector_e), 32'd0);
    check_eq("t1_port_data_zero", 32'(data_in), 32'd0);
    drain_en = 1'b0;

    // test 2: fill, overflow drop, in-order drain
    push(2'd0, 8'h11);
    push(2'd1, 8'h22);
    push(2'd2, 8'h33);
    push(2'd3, 8'h44);
    check_eq("t2_level_full", 32'(level), 32'd4);
    check_eq("t2_ready_full", 32'(wr_ready), 32'd0);
    check_eq("t2_wbit_stalled", 32'(write_bit), 32'd0);
    check_eq("t2_head_shown", 32'(data_in), 32'h11);
    wr_valid = 1'b1; wr_sel = 2'd0; wr_data = 8'h55;
    #1;
    check_eq("t2_ready_5th", 32'(wr_ready), 32'd0);
    tick();
    wr_valid = 1'b0;
    check_eq("t2_level_after_drop", 32'(level), 32'd4);
    exp_q.push_back({2'd0, 8'h11});
    exp_q.push_back({2'd1, 8'h22});
    exp_q.push_back({2'd2, 8'h33});
    exp_q.push_back({2'd3, 8'h44});
    drain_check(4, "t2");

    // test 3: forwarding
    push(2'd2, 8'h10);
    push(2'd2, 8'h20);
    rd_sel_a = 2'd2; rf_data_a = 8'h00;
    rd_sel_b = 2'd3; rf_data_b = 8'h5A;
    #1;
    check_eq("t3_fwd_a", 32'(fwd_data_a), 32'h20);
    check_eq("t3_fwd_b", 32'(fwd_data_b), 32'h5A);
    wr_valid = 1'b1; wr_sel = 2'd3; wr_data = 8'h77;
    #1;
    check_eq("t3_no_fwd_of_request", 32'(fwd_data_b), 32'h5A);
    wr_valid = 1'b0;
    drain_en = 1'b1;
    #1;
    check_eq("t3_fwd_while_commit", 32'(fwd_data_a), 32'h20);
`ifdef REGFILE_WQ_COALESCE_EN
    check_eq("t3_level", 32'(level), 32'd1);
    exp_q.push_back({2'd2, 8'h20});
    drain_check(1, "t3");
`else
    check_eq("t3_level", 32'(level), 32'd2);
    exp_q.push_back({2'd2, 8'h10});
    exp_q.push_back({2'd2, 8'h20});
    drain_check(2, "t3");
`endif
    rf_data_a = 8'h3C;
    #1;
    check_eq("t3_fwd_a_from_file", 32'(fwd_data_a), 32'h3C);

    // test 4: push and pop on the same edge
    push(2'd0, 8'hA1);
    push(2'd1, 8'hA2);
    check_eq("t4_level_pre", 32'(level), 32'd2);
    drain_en = 1'b1;
    wr_valid = 1'b1; wr_sel = 2'd3; wr_data = 8'h99;
    #1;
    check_eq("t4_head_commit", 32'({selector_e, data_in}), 32'({2'd0, 8'hA1}));
    tick();
    wr_valid = 1'b0;
    drain_en = 1'b0;
    #1;
    check_eq("t4_level_same", 32'(level), 32'd2);
    exp_q.push_back({2'd1, 8'hA2});
    exp_q.push_back({2'd3, 8'h99});
    drain_check(2, "t4");

    // test 5: reset discards queued entries
    push(2'd1, 8'hB1);
    push(2'd2, 8'hB2);
    push(2'd3, 8'hB3);
    check_eq("t5_level_pre", 32'(level), 32'd3);
    areset = 1'b1;
    drain_en = 1'b1;
    #1;
    check_eq("t5_wbit_in_rst", 32'(write_bit), 32'd0);
    check_eq("t5_ready_in_rst", 32'(wr_ready), 32'd0);
    tick();
    areset = 1'b0;
    #1;
    check_eq("t5_level", 32'(level), 32'd0);
    check_eq("t5_empty", 32'(empty), 32'd1);
    check_eq("t5_fwd_a_file", 32'(fwd_data_a), 32'h3C);
    for (int i = 0; i < 3; i++) begin
      check_eq("t5_no_commit", 32'(write_bit), 32'd0);
      tick();
    end
    drain_en = 1'b0;

    // test 6: same-register back-to-back pushes
    push(2'd1, 8'h01);
    push(2'd1, 8'h02);
`ifdef REGFILE_WQ_COALESCE_EN
    check_eq("t6_level", 32'(level), 32'd1);
    exp_q.push_back({2'd1, 8'h02});
    drain_check(1, "t6");
`else
    check_eq("t6_level", 32'(level), 32'd2);
    exp_q.push_back({2'd1, 8'h01});
    exp_q.push_back({2'd1, 8'h02});
    drain_check(2, "t6");
`endif

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
